// File: rtl/stride_prefetch_engine.sv
// Stride prefetch engine: trains on in-window demand reads, locks a signed
// stride with a saturating confidence counter, then issues prefetches over a
// valid/ready channel up to PF_AHEAD ahead, bounded by max_outstanding and
// the [bar, limit] window.
// Ports: clk/resetN (async active-low), en, flush, demand request
// (req_valid/req_addr/req_opcode), window (bar/limit), max_outstanding,
// prefetch channel (pf_valid/pf_addr/pf_ready), pf_done, and status
// (stride_locked, cur_stride, outstanding_cnt).
module stride_prefetch_engine #(
  parameter int unsigned ADDR_BITS   = 64,
  parameter int unsigned STRIDE_BITS = 16,
  parameter int unsigned CONF_BITS   = 2,
  parameter int unsigned CONF_THRESH = 2,
  parameter int unsigned AHEAD_BITS  = 3,
  parameter int unsigned PF_AHEAD    = 4,
  parameter int unsigned OUTS_BITS   = 4
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   req_valid,
  input  logic [ADDR_BITS-1:0]   req_addr,
  input  logic                   req_opcode,
  input  logic [ADDR_BITS-1:0]   bar,
  input  logic [ADDR_BITS-1:0]   limit,
  input  logic [OUTS_BITS-1:0]   max_outstanding,
  output logic                   pf_valid,
  output logic [ADDR_BITS-1:0]   pf_addr,
  input  logic                   pf_ready,
  input  logic                   pf_done,
  output logic                   stride_locked,
  output logic [STRIDE_BITS-1:0] cur_stride,
  output logic [OUTS_BITS-1:0]   outstanding_cnt
);

  localparam int unsigned EXT_BITS = ADDR_BITS - STRIDE_BITS;

  typedef enum logic [1:0] {S_IDLE, S_TRAIN, S_LOCKED} state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_has_last, w_has_last_nxt;
  logic [ADDR_BITS-1:0]   r_last_addr, w_last_addr_nxt;
  logic [STRIDE_BITS-1:0] r_cand, w_cand_nxt;
  logic [CONF_BITS-1:0]   r_conf, w_conf_nxt;
  logic [AHEAD_BITS-1:0]  r_issued, w_issued_nxt;
  logic [ADDR_BITS-1:0]   r_pf_next, w_pf_next_nxt;
  logic                   r_pf_stop, w_pf_stop_nxt;
  logic                   r_pf_valid, w_pf_valid_nxt;
  logic [ADDR_BITS-1:0]   r_pf_addr, w_pf_addr_nxt;
  logic [STRIDE_BITS-1:0] r_cur_stride, w_cur_stride_nxt;
  logic [OUTS_BITS-1:0]   r_outs, w_outs_nxt;
  logic                   r_locked;

  // Training qualification and stride difference
  logic                      w_train, w_nz_event, w_diff_fits, w_match, w_hs, w_unlock;
  logic [ADDR_BITS-1:0]      w_diff, w_lock_next;
  logic [EXT_BITS:0]         w_diff_hi;
  logic [ADDR_BITS:0]        w_pf_sum;
  logic [CONF_BITS-1:0]      w_conf_inc;

  assign w_train     = en & req_valid & ~req_opcode & (req_addr >= bar) & (req_addr <= limit);
  assign w_diff      = req_addr - r_last_addr;
  assign w_nz_event  = w_train & r_has_last & (w_diff != '0);
  assign w_diff_hi   = w_diff[ADDR_BITS-1:STRIDE_BITS-1];
  assign w_diff_fits = (&w_diff_hi) | ~(|w_diff_hi);
  assign w_match     = w_diff_fits & (w_diff[STRIDE_BITS-1:0] == r_cand);
  assign w_hs        = r_pf_valid & pf_ready;
  assign w_unlock    = w_nz_event & (r_state == S_LOCKED) & ~w_match & (r_conf == CONF_BITS'(1));
  assign w_conf_inc  = r_conf + CONF_BITS'(1);
  assign w_lock_next = req_addr + {{EXT_BITS{w_diff[STRIDE_BITS-1]}}, w_diff[STRIDE_BITS-1:0]};
  // Extra top bit flags carry/borrow out of the prefetch address step
  assign w_pf_sum    = {1'b0, r_pf_next} + {{(EXT_BITS+1){r_cur_stride[STRIDE_BITS-1]}}, r_cur_stride};

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state      <= S_IDLE;
      r_has_last   <= 1'b0;
      r_last_addr  <= '0;
      r_cand       <= '0;
      r_conf       <= '0;
      r_issued     <= '0;
      r_pf_next    <= '0;
      r_pf_stop    <= 1'b0;
      r_pf_valid   <= 1'b0;
      r_pf_addr    <= '0;
      r_cur_stride <= '0;
      r_outs       <= '0;
      r_locked     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_has_last   <= w_has_last_nxt;
      r_last_addr  <= w_last_addr_nxt;
      r_cand       <= w_cand_nxt;
      r_conf       <= w_conf_nxt;
      r_issued     <= w_issued_nxt;
      r_pf_next    <= w_pf_next_nxt;
      r_pf_stop    <= w_pf_stop_nxt;
      r_pf_valid   <= w_pf_valid_nxt;
      r_pf_addr    <= w_pf_addr_nxt;
      r_cur_stride <= w_cur_stride_nxt;
      r_outs       <= w_outs_nxt;
      r_locked     <= (w_state_nxt == S_LOCKED);
    end
  end

  // Next-state: outstanding tracking, handshake, generation, training, flush
  always_comb begin
    w_state_nxt      = r_state;
    w_has_last_nxt   = r_has_last;
    w_last_addr_nxt  = r_last_addr;
    w_cand_nxt       = r_cand;
    w_conf_nxt       = r_conf;
    w_issued_nxt     = r_issued;
    w_pf_next_nxt    = r_pf_next;
    w_pf_stop_nxt    = r_pf_stop;
    w_pf_valid_nxt   = r_pf_valid;
    w_pf_addr_nxt    = r_pf_addr;
    w_cur_stride_nxt = r_cur_stride;
    w_outs_nxt       = r_outs;

    // Completion counting is independent of en and flush
    if (w_hs && !pf_done && (r_outs != '1))
      w_outs_nxt = r_outs + OUTS_BITS'(1);
    else if (!w_hs && pf_done && (r_outs != '0))
      w_outs_nxt = r_outs - OUTS_BITS'(1);

    if (flush) begin
      w_state_nxt      = S_IDLE;
      w_has_last_nxt   = 1'b0;
      w_conf_nxt       = '0;
      w_cand_nxt       = '0;
      w_cur_stride_nxt = '0;
      w_issued_nxt     = '0;
      w_pf_stop_nxt    = 1'b0;
      w_pf_valid_nxt   = 1'b0;
      w_pf_addr_nxt    = '0;
    end else begin
      if (w_hs) begin
        w_pf_valid_nxt = 1'b0;
        w_pf_next_nxt  = w_pf_sum[ADDR_BITS-1:0];
        w_issued_nxt   = r_issued + AHEAD_BITS'(1);
        if (w_pf_sum[ADDR_BITS])
          w_pf_stop_nxt = 1'b1;
      end

      // Suppressed in the unlock cycle so no new request follows the stride loss
      if ((r_state == S_LOCKED) && en && !r_pf_valid && !r_pf_stop && !w_unlock &&
          (r_issued < AHEAD_BITS'(PF_AHEAD)) && (r_outs < max_outstanding)) begin
        if ((r_pf_next >= bar) && (r_pf_next <= limit)) begin
          w_pf_valid_nxt = 1'b1;
          w_pf_addr_nxt  = r_pf_next;
        end else begin
          w_pf_stop_nxt = 1'b1;
        end
      end

      if (w_train && !r_has_last) begin
        w_last_addr_nxt = req_addr;
        w_has_last_nxt  = 1'b1;
      end else if (w_nz_event) begin
        w_last_addr_nxt = req_addr;
        unique case (r_state)
          S_IDLE: begin
            if (w_diff_fits) begin
              w_cand_nxt  = w_diff[STRIDE_BITS-1:0];
              w_conf_nxt  = CONF_BITS'(1);
              w_state_nxt = S_TRAIN;
              if (CONF_THRESH == 1) begin
                w_state_nxt      = S_LOCKED;
                w_cur_stride_nxt = w_diff[STRIDE_BITS-1:0];
                w_pf_next_nxt    = w_lock_next;
                w_issued_nxt     = '0;
                w_pf_stop_nxt    = 1'b0;
              end
            end
          end
          S_TRAIN: begin
            if (w_match) begin
              w_conf_nxt = w_conf_inc;
              if (w_conf_inc == CONF_BITS'(CONF_THRESH)) begin
                w_state_nxt      = S_LOCKED;
                w_cur_stride_nxt = r_cand;
                w_pf_next_nxt    = w_lock_next;
                w_issued_nxt     = '0;
                w_pf_stop_nxt    = 1'b0;
              end
            end else if (w_diff_fits) begin
              w_cand_nxt = w_diff[STRIDE_BITS-1:0];
              w_conf_nxt = CONF_BITS'(1);
            end else begin
              w_state_nxt = S_IDLE;
              w_conf_nxt  = '0;
            end
          end
          S_LOCKED: begin
            if (w_match) begin
              if (r_conf != '1)
                w_conf_nxt = w_conf_inc;
              // A demand hit consumes one run-ahead slot unless a handshake refills it
              if (w_hs)
                w_issued_nxt = r_issued;
              else if (r_issued != '0)
                w_issued_nxt = r_issued - AHEAD_BITS'(1);
            end else begin
              w_conf_nxt = r_conf - CONF_BITS'(1);
              if (w_unlock) begin
                w_state_nxt      = S_IDLE;
                w_cur_stride_nxt = '0;
                w_issued_nxt     = '0;
              end
            end
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end
    end
  end

  assign pf_valid        = r_pf_valid;
  assign pf_addr         = r_pf_addr;
  assign stride_locked   = r_locked;
  assign cur_stride      = r_cur_stride;
  assign outstanding_cnt = r_outs;

endmodule

// File: tb/tb_stride_prefetch_engine.sv
// Self-checking bench for stride_prefetch_engine: expected prefetch addresses
// are queued when training stimulus is driven and popped on each handshake.
module tb_stride_prefetch_engine;

  localparam int unsigned ADDR_BITS   = 64;
  localparam int unsigned STRIDE_BITS = 16;
  localparam int unsigned OUTS_BITS   = 4;

  logic                   clk;
  logic                   resetN;
  logic                   en;
  logic                   flush;
  logic                   req_valid;
  logic [ADDR_BITS-1:0]   req_addr;
  logic                   req_opcode;
  logic [ADDR_BITS-1:0]   bar;
  logic [ADDR_BITS-1:0]   limit;
  logic [OUTS_BITS-1:0]   max_outstanding;
  logic                   pf_valid;
  logic [ADDR_BITS-1:0]   pf_addr;
  logic                   pf_ready;
  logic                   pf_done;
  logic                   stride_locked;
  logic [STRIDE_BITS-1:0] cur_stride;
  logic [OUTS_BITS-1:0]   outstanding_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int n_hs    = 0;
  int n_extra = 0;
  logic [63:0] sb[$];

  stride_prefetch_engine dut (
    .clk(clk), .resetN(resetN), .en(en), .flush(flush),
    .req_valid(req_valid), .req_addr(req_addr), .req_opcode(req_opcode),
    .bar(bar), .limit(limit), .max_outstanding(max_outstanding),
    .pf_valid(pf_valid), .pf_addr(pf_addr), .pf_ready(pf_ready),
    .pf_done(pf_done), .stride_locked(stride_locked),
    .cur_stride(cur_stride), .outstanding_cnt(outstanding_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change only 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [63:0] a);
    req_valid = 1'b1; req_addr = a; req_opcode = 1'b0;
    tick(1);
    req_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1; tick(1); flush = 1'b0;
  endtask

  task automatic drain(input int n);
    pf_done = 1'b1; tick(n); pf_done = 1'b0;
  endtask

  task automatic wait_sb(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick(1);
    chk("sb_drain", 64'(sb.size()), 64'd0);
    tick(8);
  endtask

  task automatic wait_pfv(input int budget);
    for (int i = 0; i < budget && !pf_valid; i++) tick(1);
    chk("pfv_wait", 64'(pf_valid), 64'd1);
  endtask

  // Scoreboard: every handshake pops one expected address
  always @(negedge clk) begin
    if (resetN && pf_valid && pf_ready) begin
      n_hs++;
      if (sb.size() == 0) n_extra++;
      else chk("pf_addr", pf_addr, sb.pop_front());
    end
  end

  initial begin
    resetN = 1'b0; en = 1'b1; flush = 1'b0; req_valid = 1'b0; req_addr = '0;
    req_opcode = 1'b0; bar = '0; limit = 64'hFFFF; max_outstanding = 4'd15;
    pf_ready = 1'b1; pf_done = 1'b0;
    tick(3);
    chk("rst_pfv", 64'(pf_valid), 64'd0);
    chk("rst_lock", 64'(stride_locked), 64'd0);
    chk("rst_outs", 64'(outstanding_cnt), 64'd0);
    resetN = 1'b1;
    tick(2);

    // Positive stride: lock, four run-ahead prefetches, then stop
    rd(64'h1000); rd(64'h1040); rd(64'h1080);
    chk("lock1", 64'(stride_locked), 64'd1);
    chk("stride1", 64'(cur_stride), 64'h40);
    sb.push_back(64'h10C0); sb.push_back(64'h1100);
    sb.push_back(64'h1140); sb.push_back(64'h1180);
    wait_sb(40);
    chk("hs_ahead", 64'(n_hs), 64'd4);
    chk("outs4", 64'(outstanding_cnt), 64'd4);
    chk("pfv_idle", 64'(pf_valid), 64'd0);
    // A demand hit frees one run-ahead slot
    sb.push_back(64'h11C0);
    rd(64'h10C0);
    wait_sb(20);
    chk("hs_refill", 64'(n_hs), 64'd5);
    chk("outs5", 64'(outstanding_cnt), 64'd5);
    // Confidence 3 decays over three mismatches; same-address reads ignored
    rd(64'h11C0); rd(64'h11C0); rd(64'h12C0); rd(64'h12C0);
    chk("still_lock", 64'(stride_locked), 64'd1);
    rd(64'h13C0);
    chk("unlock", 64'(stride_locked), 64'd0);
    chk("unlock_stride", 64'(cur_stride), 64'd0);
    drain(6);
    chk("outs_sat0", 64'(outstanding_cnt), 64'd0);
    chk("no_extra1", 64'(n_extra), 64'd0);

    // Negative stride
    pulse_flush();
    rd(64'h2000); rd(64'h1FC0); rd(64'h1F80);
    chk("stride_neg", 64'(cur_stride), 64'hFFC0);
    sb.push_back(64'h1F40); sb.push_back(64'h1F00);
    sb.push_back(64'h1EC0); sb.push_back(64'h1E80);
    wait_sb(40);
    chk("hs_neg", 64'(n_hs), 64'd9);
    pulse_flush();
    drain(4);

    // Window top stops generation
    limit = 64'h1100;
    rd(64'h1000); rd(64'h1040); rd(64'h1080);
    sb.push_back(64'h10C0); sb.push_back(64'h1100);
    wait_sb(30);
    chk("hs_limit", 64'(n_hs), 64'd11);
    chk("pfv_stop", 64'(pf_valid), 64'd0);
    chk("no_extra2", 64'(n_extra), 64'd0);
    pulse_flush();
    drain(2);
    limit = 64'hFFFF;

    // Outstanding cap
    max_outstanding = 4'd2;
    rd(64'h1000); rd(64'h1040); rd(64'h1080);
    sb.push_back(64'h10C0); sb.push_back(64'h1100);
    wait_sb(30);
    tick(10);
    chk("hs_cap", 64'(n_hs), 64'd13);
    chk("outs_cap", 64'(outstanding_cnt), 64'd2);
    sb.push_back(64'h1140);
    drain(1);
    wait_sb(20);
    chk("hs_after_done", 64'(n_hs), 64'd14);
    chk("outs_after_done", 64'(outstanding_cnt), 64'd2);
    // Handshake coincident with pf_done leaves count unchanged
    max_outstanding = 4'd3; pf_ready = 1'b0;
    sb.push_back(64'h1180);
    wait_pfv(20);
    pf_ready = 1'b1; pf_done = 1'b1;
    tick(1);
    pf_ready = 1'b0; pf_done = 1'b0;
    tick(2);
    chk("hs_coinc", 64'(n_hs), 64'd15);
    chk("outs_coinc", 64'(outstanding_cnt), 64'd2);

    // Flush drops an unaccepted prefetch, keeps outstanding
    pulse_flush();
    max_outstanding = 4'd15;
    rd(64'h1000); rd(64'h1040); rd(64'h1080);
    wait_pfv(20);
    chk("held_addr", pf_addr, 64'h10C0);
    pulse_flush();
    chk("flush_pfv", 64'(pf_valid), 64'd0);
    chk("flush_outs", 64'(outstanding_cnt), 64'd2);
    chk("flush_lock", 64'(stride_locked), 64'd0);

    // Asynchronous reset mid-operation
    rd(64'h1000); rd(64'h1040); rd(64'h1080);
    wait_pfv(20);
    resetN = 1'b0;
    #1;
    chk("arst_pfv", 64'(pf_valid), 64'd0);
    chk("arst_addr", pf_addr, 64'd0);
    chk("arst_lock", 64'(stride_locked), 64'd0);
    chk("arst_outs", 64'(outstanding_cnt), 64'd0);
    chk("no_extra3", 64'(n_extra), 64'd0);
    tick(2);
    resetN = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/stride_prefetch_engine.md
Name: stride_prefetch_engine

Overview:
- Next-generation stride prefetcher for the memory request path: trains on in-window demand reads and locks a signed stride using a saturating confidence counter.
- When locked, issues prefetch addresses over a valid/ready channel, up to a configurable run-ahead depth.
- Generation is bounded by a runtime outstanding-request limit and the bar/limit window.
- Adds flush, confidence hysteresis, negative strides and completion tracking.

Parameters:
- ADDR_BITS, 64: address width.
- STRIDE_BITS, 16: signed stride width, two's complement.
- CONF_BITS, 2: confidence counter width.
- CONF_THRESH, 2: confidence level at which the engine locks; range 1..2^CONF_BITS-1.
- AHEAD_BITS, 3: width of the run-ahead counter.
- PF_AHEAD, 4: maximum number of prefetches issued ahead of demand; must be < 2^AHEAD_BITS.
- OUTS_BITS, 4: width of the outstanding counter and of max_outstanding.

Ports:
- clk  in  1  clock
- resetN  in  1  asynchronous, active-low reset
- en  in  1  global enable
- flush  in  1  synchronous flush of training and generation state
- req_valid  in  1  demand request valid
- req_addr  in  ADDR_BITS  demand address
- req_opcode  in  1  0 = read, 1 = write (writes ignored)
- bar  in  ADDR_BITS  window base, inclusive
- limit  in  ADDR_BITS  window top, inclusive
- max_outstanding  in  OUTS_BITS  cap on in-flight prefetches; 0 disables generation
- pf_valid  out  1  prefetch request valid (registered)
- pf_addr  out  ADDR_BITS  prefetch address (registered)
- pf_ready  in  1  downstream accepts prefetch
- pf_done  in  1  one prefetch completed
- stride_locked  out  1  FSM is in S_LOCKED
- cur_stride  out  STRIDE_BITS  locked stride; 0 when not locked
- outstanding_cnt  out  OUTS_BITS  prefetches issued but not yet completed

Behaviour:
- Reset: all outputs go to 0. FSM = S_IDLE; has_last, last_addr, cand, conf, issued_ahead, pf_next and pf_stop are cleared.

Training
- A training event is en & req_valid & !req_opcode & bar<=req_addr<=limit.
- First event with has_last=0: last_addr <= req_addr, has_last <= 1. Nothing else changes.
- Otherwise diff = req_addr - last_addr, computed modulo 2^ADDR_BITS.
- diff==0: the event is ignored entirely (last_addr and state unchanged).
- diff is "valid" if it sign-fits STRIDE_BITS; a non-fitting diff is always a mismatch.
- Every non-zero event updates last_addr.
- match = valid & (diff[STRIDE_BITS-1:0] == cand).

FSM
- S_IDLE, on a valid diff: cand <= diff, conf <= 1. Go to S_TRAIN, or directly to S_LOCKED if CONF_THRESH==1.
- S_TRAIN, on match: conf++. When the new conf == CONF_THRESH, go to S_LOCKED with:
  - cur_stride <= cand
  - pf_next <= req_addr + sext(cand)
  - issued_ahead <= 0, pf_stop <= 0
- S_TRAIN, on mismatch: cand <= diff (if valid), conf <= 1; stay in S_TRAIN. An invalid diff goes to S_IDLE.
- S_LOCKED, on match: conf saturating increment; issued_ahead-- if >0 (demand consumed one prefetch).
- S_LOCKED, on mismatch: conf--. At 0: go to S_IDLE, cur_stride <= 0, issued_ahead <= 0, and any pending pf_valid is held until its handshake. pf_next is unchanged on mismatch.

Generation (S_LOCKED only)
- Candidate condition: en & !pf_valid & !pf_stop & issued_ahead<PF_AHEAD & outstanding_cnt<max_outstanding.
- If pf_next lies in [bar,limit]: next cycle pf_valid <= 1, pf_addr <= pf_next. Otherwise pf_stop <= 1.
- pf_stop stays set until the next lock.
- pf_valid/pf_addr are held stable until pf_valid&pf_ready, even if en drops or the FSM leaves S_LOCKED. Only flush or reset clears them.
- On handshake:
  - pf_valid <= 0
  - pf_next <= pf_next + sext(cur_stride)
  - issued_ahead++, outstanding_cnt++
- Carry or borrow out of the pf_next addition sets pf_stop (no wrap-around).
- Issue rate is at most one prefetch per 2 cycles.
- Simultaneous handshake and demand match in the same cycle: issued_ahead is unchanged.

Outstanding
- pf_done: outstanding_cnt-- (saturating at 0).
- Handshake and pf_done in the same cycle: outstanding_cnt is unchanged.
- pf_done is counted regardless of en and flush.

Flush
- Highest synchronous priority.
- Clears FSM to S_IDLE, has_last, conf, cand, cur_stride, issued_ahead, pf_stop, and pf_valid (even when unaccepted).
- outstanding_cnt is retained.
- A request presented in a flush cycle is not trained.

en=0
- Freezes training and new generation.
- pf_done counting and the held pf_valid handshake still operate.

Test Plan:
- Window 0..0xFFFF, reads 0x1000,0x1040,0x1080, pf_ready=1, max_outstanding=15 -> stride_locked=1 and cur_stride=0x0040 after the third read. pf_addr sequence is 0x10C0,0x1100,0x1140,0x1180, then generation stops (PF_AHEAD=4). A further read at 0x10C0 allows 0x11C0.
- Reads 0x2000,0x1FC0,0x1F80 -> cur_stride=0xFFC0 (-64), first pf_addr=0x1F40.
- limit=0x1100 with the first scenario's training -> only 0x10C0 and 0x1100 are issued, then pf_stop; pf_valid stays 0.
- max_outstanding=2, no pf_done -> exactly 2 handshakes, outstanding_cnt=2. A pf_done pulse allows a third. pf_done coincident with a handshake -> count unchanged.
- Locked with conf saturated at 3: three reads with stride 0x100 -> stride_locked falls on the third, cur_stride=0. Repeated reads at the same address in between cause no state change.
- pf_valid=1 with pf_ready=0, assert flush -> pf_valid=0 next cycle, outstanding_cnt retained. Assert resetN=0 mid-operation -> all outputs 0 immediately.
